vga_mem_fetch: RTL

VGA_MEM_FETCH -- requirements
Module: vga_mem_fetch

---
 rtl/vga_mem_fetch_pkg.sv | 13 +
 rtl/vga_mem_fetch_if.sv | 38 +++
 rtl/vga_mem_fetch_pipe.sv | 41 ++++
 rtl/vga_mem_fetch.sv | 124 ++++++++++++
 4 files changed

// File: rtl/vga_mem_fetch_pkg.sv
// Shared constants for the VGA frame-buffer fetch unit.
// Word/address widths, frame bases and raster limits.
package vga_mem_fetch_pkg;

    localparam int LOG_MEM     = 36;
    localparam int LOG_ADDR    = 19;
    localparam int FRAME0_BASE = 0;
    localparam int FRAME1_BASE = 153600;
    localparam int H_LIMIT     = 640;
    localparam int V_LIMIT     = 480;
    localparam int LINE_WORDS  = 320;

endpackage

// File: rtl/vga_mem_fetch_if.sv
// Bundle of display, camera-writer and memory signals.
// The slave modport is the fetch unit, master is its environment.
interface vga_mem_fetch_if #(
    parameter int LOG_MEM  = 36,
    parameter int LOG_ADDR = 19
);

    logic                vga_flag;
    logic [9:0]          clocked_hcount;
    logic [9:0]          clocked_vcount;
    logic                frame_sel;
    logic                write_req;
    logic [LOG_ADDR-1:0] write_addr;
    logic [LOG_MEM-1:0]  write_data;
    logic                write_ack;
    logic [LOG_ADDR-1:0] mem_addr;
    logic                mem_we;
    logic [LOG_MEM-1:0]  mem_wdata;
    logic [LOG_MEM-1:0]  mem_rdata;
    logic [LOG_MEM-1:0]  vga_pixel;
    logic                done_vga;
    logic                overrun;

    modport slave (
        input  vga_flag, clocked_hcount, clocked_vcount, frame_sel,
        input  write_req, write_addr, write_data, mem_rdata,
        output write_ack, mem_addr, mem_we, mem_wdata,
        output vga_pixel, done_vga, overrun
    );

    modport master (
        output vga_flag, clocked_hcount, clocked_vcount, frame_sel,
        output write_req, write_addr, write_data, mem_rdata,
        input  write_ack, mem_addr, mem_we, mem_wdata,
        input  vga_pixel, done_vga, overrun
    );

endinterface

// File: rtl/vga_mem_fetch_pipe.sv
// fetch_pipe: N-stage valid/data delay line.
// Data moves only alongside a valid beat; N=0 is a wire.
module fetch_pipe #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         vld_i,
    input  logic [W-1:0] dat_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    if (N == 0) begin : g_thru
        assign vld_o = vld_i;
        assign dat_o = dat_i;
    end else begin : g_regs
        logic [N-1:0] vld_q;
        logic [W-1:0] dat_q [N];

        // Shift valids every cycle, data only with its valid
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= '0;
                for (int i = 0; i < N; i++) dat_q[i] <= '0;
            end else begin
                vld_q[0] <= vld_i;
                if (vld_i) dat_q[0] <= dat_i;
                for (int i = 1; i < N; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
                end
            end
        end

        assign vld_o = vld_q[N-1];
        assign dat_o = dat_q[N-1];
    end

endmodule

// File: rtl/vga_mem_fetch.sv
// Frame-buffer arbiter: display pixel-pair reads win over camera
// writes; read data and write data are aligned to memory latency.
module vga_mem_fetch #(
    parameter int LOG_MEM     = vga_mem_fetch_pkg::LOG_MEM,
    parameter int LOG_ADDR    = vga_mem_fetch_pkg::LOG_ADDR,
    parameter int MEM_LATENCY = 2
) (
    input logic            clock,
    input logic            reset,
    vga_mem_fetch_if.slave bus
);

    import vga_mem_fetch_pkg::*;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                in_idle, rd_go, wr_go;
    logic                oob, frame_start;
    logic [LOG_ADDR-1:0] base_q, base_d, rd_addr, v_ext;
    logic [LOG_ADDR-1:0] mem_addr_q;
    logic                mem_we_q, ack_q, done_q, ovr_q;
    logic [LOG_MEM-1:0]  pix_q, wdata_q;
    logic                cap_vld, cap_oob, wd_vld;
    logic [LOG_MEM-1:0]  wd_dat;

    assign in_idle = (state_q == S_IDLE);
    assign oob = (bus.clocked_hcount >= 10'(H_LIMIT))
              || (bus.clocked_vcount >= 10'(V_LIMIT));
    assign frame_start = (bus.clocked_vcount == 10'd0)
                      && (bus.clocked_hcount < 10'd2);

    // Next state: reads beat writes; a write held off by a read goes next
    always_comb begin
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE: begin
                if (bus.vga_flag)       state_d = S_READ;
                else if (bus.write_req) state_d = S_WRITE;
            end
            S_READ:  if (bus.write_req) state_d = S_WRITE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_go = (state_d == S_READ);
    assign wr_go = (state_d == S_WRITE);

    // Buffer choice only changes at the top-left pixel of a frame
    always_comb begin
        base_d = base_q;
        if (rd_go && frame_start)
            base_d = bus.frame_sel ? LOG_ADDR'(FRAME1_BASE)
                                   : LOG_ADDR'(FRAME0_BASE);
    end

    assign v_ext   = LOG_ADDR'(bus.clocked_vcount);
    assign rd_addr = base_d + (v_ext << 8) + (v_ext << 6)
                   + LOG_ADDR'(bus.clocked_hcount[9:1]);

    // Arbiter state and memory command registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            ack_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            mem_we_q <= wr_go;
            ack_q    <= wr_go;
            if (wr_go)
                mem_addr_q <= bus.write_addr;
            else if (rd_go && !oob)
                mem_addr_q <= rd_addr;
            ovr_q <= ovr_q | (bus.vga_flag & ~in_idle);
        end
    end

    fetch_pipe #(.N(MEM_LATENCY + 1), .W(1)) u_rd_pipe (
        .clk_i  (clock),
        .rst_ni (reset),
        .vld_i  (rd_go),
        .dat_i  (oob),
        .vld_o  (cap_vld),
        .dat_o  (cap_oob)
    );

    fetch_pipe #(.N(MEM_LATENCY), .W(LOG_MEM)) u_wd_pipe (
        .clk_i  (clock),
        .rst_ni (reset),
        .vld_i  (wr_go),
        .dat_i  (bus.write_data),
        .vld_o  (wd_vld),
        .dat_o  (wd_dat)
    );

    // Capture returning read data and present delayed write data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix_q   <= '0;
            done_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            done_q <= cap_vld;
            if (cap_vld) pix_q <= cap_oob ? '0 : bus.mem_rdata;
            if (wd_vld) wdata_q <= wd_dat;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.write_ack = ack_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.vga_pixel = pix_q;
    assign bus.done_vga  = done_q;
    assign bus.overrun   = ovr_q;

endmodule
